// File: rtl/wisc_pkg.sv
// Shared WISC definitions: ALUOp encodings, default widths and the ID/EX halt FSM states.
// The ALU control decoder uses the same ALUOp constants.
package wisc_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;
  localparam int CW_DEF = 16;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ADD  = 5'b11011;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  function automatic logic is_halt(input logic [4:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage.
// The master modport drives decode fields and the EX/MEM controls; the slave is the stage.
interface id_ex_stage_if
  import wisc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
);
  logic          id_valid;
  logic          id_ready;
  logic [4:0]    id_alu_op;
  logic [1:0]    id_alu_f;
  logic [DW-1:0] id_a, id_b, id_imm, id_pc;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_rs_used, id_rt_used;
  logic          id_reg_we, id_mem_rd, id_mem_wr;
  logic          ex_ready;
  logic          flush;
  logic          ex_valid;
  logic [4:0]    ex_alu_op;
  logic [1:0]    ex_alu_f;
  logic [DW-1:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic          halted;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_alu_op, id_alu_f, id_a, id_b, id_imm, id_pc,
           id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_reg_we, id_mem_rd, id_mem_wr, ex_ready, flush,
    input  id_ready, ex_valid, ex_alu_op, ex_alu_f, ex_a, ex_b, ex_imm, ex_pc,
           ex_rs, ex_rt, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_alu_op, id_alu_f, id_a, id_b, id_imm, id_pc,
           id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_reg_we, id_mem_rd, id_mem_wr, ex_ready, flush,
    output id_ready, ex_valid, ex_alu_op, ex_alu_f, ex_a, ex_b, ex_imm, ex_pc,
           ex_rs, ex_rt, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use compare: the instruction in EX is a load whose destination a live ID source reads.
// Purely combinational so the forwarding unit can share it.
module hazard_detect
  import wisc_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          i_ex_valid,
  input  logic          i_ex_mem_rd,
  input  logic          i_ex_reg_we,
  input  logic [RW-1:0] i_ex_rd,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  input  logic          i_id_rs_used,
  input  logic          i_id_rt_used,
  output logic          o_load_use
);
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = i_id_rs_used && (i_id_rs == i_ex_rd);
  assign w_rt_hit   = i_id_rt_used && (i_id_rt == i_ex_rd);
  assign o_load_use = i_ex_valid && i_ex_mem_rd && i_ex_reg_we && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, downstream hold, branch flush,
// a HALT latch and a saturating stalled-decode counter.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);
  logic          r_valid;
  logic [4:0]    r_alu_op;
  logic [1:0]    r_alu_f;
  logic [DW-1:0] r_a, r_b, r_imm, r_pc;
  logic [RW-1:0] r_rs, r_rt, r_rd;
  logic          r_reg_we, r_mem_rd, r_mem_wr;
  logic [CW-1:0] r_stall_cnt;
  state_e        r_state;
  state_e        w_state_next;

  logic w_advance, w_load_use, w_halted, w_id_ready, w_capture, w_stall_inc;

  hazard_detect #(.RW(RW)) u_hazard (
    .i_ex_valid   (r_valid),
    .i_ex_mem_rd  (r_mem_rd),
    .i_ex_reg_we  (r_reg_we),
    .i_ex_rd      (r_rd),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_rs_used (bus.id_rs_used),
    .i_id_rt_used (bus.id_rt_used),
    .o_load_use   (w_load_use)
  );

  // Flush blocks acceptance outright, so it also pre-empts HALT entry and load-use stalls.
  assign w_advance   = !r_valid || bus.ex_ready;
  assign w_halted    = (r_state == HALTED);
  assign w_id_ready  = w_advance && !w_load_use && !w_halted && !bus.flush;
  assign w_capture   = bus.id_valid && w_id_ready;
  assign w_stall_inc = bus.id_valid && !w_id_ready && !w_halted && !bus.flush;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_capture && is_halt(bus.id_alu_op)) w_state_next = HALTED;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  // Bubbles clear only valid and the control bits; payload is left stale for downstream to ignore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_alu_op <= '0;
      r_alu_f  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_reg_we <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_alu_op <= bus.id_alu_op;
      r_alu_f  <= bus.id_alu_f;
      r_a      <= bus.id_a;
      r_b      <= bus.id_b;
      r_imm    <= bus.id_imm;
      r_pc     <= bus.id_pc;
      r_rs     <= bus.id_rs;
      r_rt     <= bus.id_rt;
      r_rd     <= bus.id_rd;
      r_reg_we <= bus.id_reg_we;
      r_mem_rd <= bus.id_mem_rd;
      r_mem_wr <= bus.id_mem_wr;
    end else if (w_advance) begin
      r_valid  <= 1'b0;
      r_reg_we <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end
  end

  assign bus.id_ready  = w_id_ready;
  assign bus.ex_valid  = r_valid;
  assign bus.ex_alu_op = r_alu_op;
  assign bus.ex_alu_f  = r_alu_f;
  assign bus.ex_a      = r_a;
  assign bus.ex_b      = r_b;
  assign bus.ex_imm    = r_imm;
  assign bus.ex_pc     = r_pc;
  assign bus.ex_rs     = r_rs;
  assign bus.ex_rt     = r_rt;
  assign bus.ex_rd     = r_rd;
  assign bus.ex_reg_we = r_reg_we;
  assign bus.ex_mem_rd = r_mem_rd;
  assign bus.ex_mem_wr = r_mem_wr;
  assign bus.halted    = w_halted;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage for the 16-bit WISC core. It registers decoded instruction fields and operands, and presents registered ALUOp/ALUF to the ALU control decoder and ALU in EX. It detects load-use hazards and inserts bubbles, and honours downstream stalls and branch flushes. It also latches HALT and keeps a saturating stall counter.

Parameters:
DW, 16, datapath width (operands, immediate, PC)
RW, 3, register specifier width
CW, 16, stall counter width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
id_valid  in  1  decode holds a valid instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_alu_op  in  5  decoded ALUOp
id_alu_f  in  2  function bits instr[1:0]
id_a, id_b  in  DW  register operands
id_imm  in  DW  extended immediate
id_pc  in  DW  PC+2 of the instruction
id_rs, id_rt, id_rd  in  RW  source and destination specifiers
id_rs_used, id_rt_used  in  1  source is read by the instruction
id_reg_we, id_mem_rd, id_mem_wr  in  1  control bits
ex_ready  in  1  EX/MEM can take the held instruction this cycle
flush  in  1  branch/jump taken in EX; kill the instruction in ID
ex_valid  out  1  EX register holds a live instruction
ex_alu_op, ex_alu_f  out  5/2  registered ALUOp/ALUF
ex_a, ex_b, ex_imm, ex_pc  out  DW  registered payload
ex_rs, ex_rt, ex_rd  out  RW  registered specifiers
ex_reg_we, ex_mem_rd, ex_mem_wr  out  1  registered control; always 0 when ex_valid=0
halted  out  1  HALT reached EX; the pipeline is frozen
stall_cnt  out  CW  saturating count of stalled decode cycles

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, all ex_* outputs=0, halted=0, stall_cnt=0, FSM=RUN. On release, the first capture can occur at the first rising edge.
- advance = ~ex_valid | ex_ready.
- load_use = ex_valid & ex_mem_rd & ex_reg_we & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- id_ready = advance & ~load_use & ~halted & ~flush (combinational).
- Capture (id_valid & id_ready): next edge loads all ex_* from id_*, ex_valid=1. Latency 1 cycle.
- Bubble (advance & ~capture): ex_valid=0 and ex_reg_we/ex_mem_rd/ex_mem_wr=0. Payload holds its old value; downstream must ignore it.
- Hold (~advance): every EX register keeps its value, including ex_valid. A load-use condition against a held load persists, so no bubble is inserted until advance.
- flush: kills the ID instruction (id_ready=0). If advance, a bubble enters EX. The EX instruction itself (the branch) is never killed. Flush has priority over load_use and over HALT entry.
- FSM RUN->HALTED: on capture of id_alu_op==5'b00000. halted=1 from the following edge. HALTED is left only by reset. While halted, id_ready=0 and no further captures occur. The HALT instruction stays in EX until ex_ready, then a bubble follows.
- stall_cnt increments each cycle with id_valid & ~id_ready & ~halted & ~flush. It saturates at all-ones with no wrap.
- Simultaneous load_use and ~advance: the hold rule wins.
- id_valid=0 with advance: a bubble is inserted and stall_cnt is not incremented.

Decomposition:
- A shared package wisc_pkg holds: the ALUOp localparams (OP_HALT=5'b00000, OP_LD=5'b10001, OP_ADD=5'b11011, ...), DW/RW defaults, and an FSM state typedef {RUN, HALTED}. The ALU control decoder uses the same constants.
- One natural sub-module, hazard_detect: purely combinational load_use compare. It is reused later by the forwarding unit.
- The pipeline register and FSM stay in id_ex_stage.

Test Plan:
- Reset mid-run: drive a capture of ADD, then pull rst_n low between edges -> ex_valid, ex_reg_we and halted go 0 immediately, with no clock edge needed.
- Back-to-back ADD r1 (A=16'h0003, B=16'h0004, alu_f=00), then SUB with ex_ready=1 -> ex_alu_op=11011 with ex_alu_f=00, then 01, on consecutive cycles. id_ready stays 1 and stall_cnt=0.
- LD r2 followed by ADD reading r2 via rs -> one cycle with id_ready=0 and a bubble (ex_valid=0, ex_reg_we=0), ADD captured next cycle, stall_cnt=1. Repeat using rt, and with id_rs_used=0 -> no stall.
- ex_ready=0 for 3 cycles with an instruction in EX -> ex_* unchanged and id_ready=0 for 3 cycles, stall_cnt=3. On ex_ready=1 the next instruction is captured.
- flush=1 while id_valid with BEQZ in EX and ex_ready=1 -> BEQZ leaves EX, a bubble enters, and the ID instruction is never captured. stall_cnt unchanged.
- HALT captured while flush=0 -> halted=1 on the next edge, id_ready stays 0 for 100 cycles, stall_cnt stays 0. HALT captured with flush=1 -> it is dropped and halted stays 0.
- Hold stall_cnt scenario: saturation check after preloading 16'hFFFE via 3 stalled cycles -> reads 16'hFFFF and does not wrap.
